conv_row_sched: RTL
===================

Name: conv_row_sched

Overview:
- Sequential scheduler for one PE's 1-D convolution over circular IF and filter scratchpads.
- Per row it walks every filter, every window position and every tap, and drives the scratchpad read addresses and the MAC enables.
- Stalls when operands are not yet written.
- Hands each partial sum to the psum stage over a valid/ready handshake, then releases the consumed IF row back to the writer.

Parameters:
IF_ADDRESS_SIZE, 8, IF scratchpad address width.
FILTER_ADDRESS_SIZE, 8, filter scratchpad address width.
STRIDE_SIZE, 2, stride port is STRIDE_SIZE+1 bits.
CELL_NUMS_IF, 8, IF scratchpad depth (any value ≥2, not necessarily a power of 2).
CELL_NUMS_FILTER, 8, filter scratchpad depth.
MAC_LATENCY, 1, cycles from the last tap's mac_en to the accumulator result being valid (1..4).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  pulse: latch config, begin one row; ignored while busy.
stride  in  STRIDE_SIZE+1  window step.
filter_size  in  3  taps per filter.
if_size  in  3  IF words per row.
if_avail  in  IF_ADDRESS_SIZE+1  valid IF words counted from if_base.
filter_avail  in  FILTER_ADDRESS_SIZE+1  valid filter words counted from address 0.
if_rd_addr  out  IF_ADDRESS_SIZE  IF read address.
filter_rd_addr  out  FILTER_ADDRESS_SIZE  filter read address.
mac_en  out  1  tap issued this cycle.
acc_clr  out  1  first tap of a window; accumulator loads instead of adding.
psum_valid  out  1  partial sum available.
psum_ready  in  1  psum stage accepts.
psum_filter  out  3  filter index of the current psum.
psum_win  out  3  window index of the current psum.
if_release  out  1  pulse: if_size words freed.
if_base  out  IF_ADDRESS_SIZE  oldest retained IF address.
busy  out  1  not IDLE.
row_done  out  1  pulse at end of row.
cfg_err  out  1  pulse on illegal start.

Behaviour:
- Reset: all outputs 0; if_base=0; state IDLE; counters f, w, k = 0. Reset mid-row aborts with no release pulse.
- Config latched at start:
  - NF = CELL_NUMS_FILTER / filter_size (integer division).
  - NW = (if_size - filter_size) / stride + 1.
- Illegal start: filter_size==0, stride==0, filter_size>if_size, or filter_size>CELL_NUMS_FILTER.
  - cfg_err pulses 1 cycle; block stays IDLE.
- States: IDLE, ISSUE, DRAIN, EMIT, RELEASE.
- IDLE: legal start moves to ISSUE next cycle.
- ISSUE, one tap per cycle:
  - off = w*stride + k; fidx = f*filter_size + k.
  - Issue when off < if_avail and fidx < filter_avail. Then:
    - mac_en=1.
    - acc_clr = (k==0).
    - if_rd_addr = (if_base + off) mod CELL_NUMS_IF.
    - filter_rd_addr = fidx mod CELL_NUMS_FILTER.
  - Otherwise mac_en=0 and nothing advances (stall). if_avail and filter_avail are sampled every cycle.
  - After issuing k = filter_size-1: go to DRAIN.
- DRAIN: wait MAC_LATENCY-1 cycles (0 cycles when MAC_LATENCY=1), then EMIT.
- EMIT:
  - psum_valid=1 with stable psum_filter=f and psum_win=w.
  - Held until psum_ready; the transfer occurs on the cycle both are 1.
  - After transfer: k=0, then w++. If w wraps past NW-1: w=0, f++.
  - If f wraps past NF-1: go to RELEASE; else return to ISSUE.
- RELEASE, one cycle:
  - if_release=1, row_done=1.
  - if_base = (if_base + if_size) mod CELL_NUMS_IF.
  - Next state IDLE.
- Modulo arithmetic: compare-and-subtract on a width+1 sum; no divider for address wrap.
- NF and NW are computed once at start; a small iterative or constant-table computation is permitted, max 3 cycles.
  - During that time busy=1 and mac_en=0.
- start asserted in RELEASE is ignored; start asserted in IDLE the cycle after RELEASE is accepted.
- psum_ready asserted outside EMIT has no effect.

Decomposition:
- Package conv_sched_pkg holds:
  - state enum;
  - width localparams (IF_PTR_W, FILT_PTR_W);
  - a modulo-add function.
- One sub-module: conv_geom_calc (NF/NW computation from the latched config).

Test Plan:
- if_size=5, filter_size=3, stride=1, avails full, psum_ready=1, if_base=0:
  - NF=2, NW=3 → 18 mac_en, 6 psums.
  - Window 1 addresses 1,2,3; filter 1 addresses 3,4,5.
  - One if_release pulse; if_base=5.
- Same config with stride=2:
  - NW=2.
  - Window 1 IF addresses 2,3,4.
  - 12 mac_en total.
- Starting from if_base=5 (after the first test), if_size=5, filter_size=3, stride=1, CELL_NUMS_IF=8:
  - Window 0 addresses 5,6,7; window 1 addresses 6,7,0; window 2 addresses 7,0,1.
  - Final if_base=2.
- if_avail=2 at start, raised to 5 ten cycles later:
  - Third tap stalls, with mac_en=0 for 10 cycles.
  - Then it resumes with the same address and psum count is unchanged.
- psum_ready low for 3 cycles in the first EMIT:
  - psum_valid stays 1 with psum_filter=0 and psum_win=0 stable.
  - No mac_en until the transfer.
- start with filter_size=4, if_size=3:
  - cfg_err=1 for one cycle; busy stays 0.
- rst asserted mid-ISSUE:
  - Next cycle all outputs are 0 and if_base=0.
  - A subsequent start runs a complete row.

Source files
------------

// File: rtl/conv_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package : conv_sched_pkg
// Brief   : Shared types, width defaults and wrap arithmetic for the 1-D
//           convolution row scheduler.
// Rev     : 1.0 - initial release
// ============================================================================
package conv_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_DRAIN   = 3'd2,
    S_EMIT    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam int IF_PTR_W   = 8;
  localparam int FILT_PTR_W = 8;

  // Enough subtract steps to fold a sum of up to MOD_STEPS+1 times the modulus.
  localparam int MOD_STEPS  = 8;

  // (a + b) mod m using compare-and-subtract on a one-bit-wider sum.
  // Assumes a < m; b may exceed m by a small multiple (shallow scratchpads).
  function automatic logic [31:0] mod_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] m);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    for (int i = 0; i < MOD_STEPS; i++) begin
      if (s >= {1'b0, m}) s = s - {1'b0, m};
    end
    return s[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_geom_calc.sv
`default_nettype none
// ============================================================================
// Module : conv_geom_calc
// Brief  : Filter count (NF) and window count (NW) for the latched row config.
//          NF comes from a constant table, NW from a short subtract loop.
// Rev    : 1.0 - initial release
// ============================================================================
module conv_geom_calc
  import conv_sched_pkg::*;
#(
  parameter int STRIDE_SIZE      = 2,
  parameter int CELL_NUMS_FILTER = 8,
  parameter int NF_W             = 4
) (
  input  logic [2:0]           filter_size,
  input  logic [2:0]           if_size,
  input  logic [STRIDE_SIZE:0] stride,
  output logic [NF_W-1:0]      nf,
  output logic [2:0]           nw
);

  logic [7:0] stp;
  logic [7:0] rem;
  logic [2:0] quo;

  // NF = depth / taps; divisors are 1..7 so each entry is a constant.
  always_comb begin
    nf = '0;
    case (filter_size)
      3'd1: nf = NF_W'(CELL_NUMS_FILTER / 1);
      3'd2: nf = NF_W'(CELL_NUMS_FILTER / 2);
      3'd3: nf = NF_W'(CELL_NUMS_FILTER / 3);
      3'd4: nf = NF_W'(CELL_NUMS_FILTER / 4);
      3'd5: nf = NF_W'(CELL_NUMS_FILTER / 5);
      3'd6: nf = NF_W'(CELL_NUMS_FILTER / 6);
      3'd7: nf = NF_W'(CELL_NUMS_FILTER / 7);
      default: nf = '0;
    endcase
  end

  // NW = (if_size - filter_size) / stride + 1; numerator is at most 6.
  always_comb begin
    stp = 8'(stride);
    rem = {5'd0, if_size - filter_size};
    quo = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (stp != 8'd0 && rem >= stp) begin
        rem = rem - stp;
        quo = quo + 3'd1;
      end
    end
    nw = quo + 3'd1;
  end

endmodule
`default_nettype wire

// File: rtl/conv_row_sched.sv
`default_nettype none
// ============================================================================
// Module : conv_row_sched
// Brief  : Per-row scheduler for a PE's 1-D convolution over circular IF and
//          filter scratchpads: issues taps, stalls on missing operands, hands
//          psums downstream and releases the consumed IF row.
// Rev    : 1.0 - initial release
// ============================================================================
module conv_row_sched
  import conv_sched_pkg::*;
#(
  parameter int IF_ADDRESS_SIZE     = IF_PTR_W,
  parameter int FILTER_ADDRESS_SIZE = FILT_PTR_W,
  parameter int STRIDE_SIZE         = 2,
  parameter int CELL_NUMS_IF        = 8,
  parameter int CELL_NUMS_FILTER    = 8,
  parameter int MAC_LATENCY         = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [STRIDE_SIZE:0]           stride,
  input  logic [2:0]                     filter_size,
  input  logic [2:0]                     if_size,
  input  logic [IF_ADDRESS_SIZE:0]       if_avail,
  input  logic [FILTER_ADDRESS_SIZE:0]   filter_avail,
  output logic [IF_ADDRESS_SIZE-1:0]     if_rd_addr,
  output logic [FILTER_ADDRESS_SIZE-1:0] filter_rd_addr,
  output logic                           mac_en,
  output logic                           acc_clr,
  output logic                           psum_valid,
  input  logic                           psum_ready,
  output logic [2:0]                     psum_filter,
  output logic [2:0]                     psum_win,
  output logic                           if_release,
  output logic [IF_ADDRESS_SIZE-1:0]     if_base,
  output logic                           busy,
  output logic                           row_done,
  output logic                           cfg_err
);

  localparam int NF_W = $clog2(CELL_NUMS_FILTER + 1);

  state_t               state;
  logic [STRIDE_SIZE:0] cfg_stride;
  logic [2:0]           cfg_fs;
  logic [2:0]           cfg_is;
  logic [NF_W-1:0]      f;
  logic [NF_W-1:0]      nf;
  logic [2:0]           w;
  logic [2:0]           k;
  logic [2:0]           nw;
  logic [1:0]           drain_cnt;
  logic [31:0]          off;
  logic [31:0]          fidx;
  logic                 can_issue;
  logic                 illegal;
  logic                 last_k;
  logic                 last_w;
  logic                 last_f;

  conv_geom_calc #(
    .STRIDE_SIZE      (STRIDE_SIZE),
    .CELL_NUMS_FILTER (CELL_NUMS_FILTER),
    .NF_W             (NF_W)
  ) u_geom (
    .filter_size (cfg_fs),
    .if_size     (cfg_is),
    .stride      (cfg_stride),
    .nf          (nf),
    .nw          (nw)
  );

  assign off       = 32'(w) * 32'(cfg_stride) + 32'(k);
  assign fidx      = 32'(f) * 32'(cfg_fs) + 32'(k);
  assign can_issue = (off < 32'(if_avail)) && (fidx < 32'(filter_avail));
  assign illegal   = (filter_size == 3'd0) || (stride == '0) ||
                     (filter_size > if_size) ||
                     (32'(filter_size) > 32'(CELL_NUMS_FILTER));
  assign last_k    = (k == cfg_fs - 3'd1);
  assign last_w    = (w == nw - 3'd1);
  assign last_f    = (f == nf - NF_W'(1));

  // Row FSM: state, loop counters and every output are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cfg_stride     <= '0;
      cfg_fs         <= '0;
      cfg_is         <= '0;
      f              <= '0;
      w              <= '0;
      k              <= '0;
      drain_cnt      <= '0;
      if_rd_addr     <= '0;
      filter_rd_addr <= '0;
      mac_en         <= 1'b0;
      acc_clr        <= 1'b0;
      psum_valid     <= 1'b0;
      psum_filter    <= '0;
      psum_win       <= '0;
      if_release     <= 1'b0;
      if_base        <= '0;
      busy           <= 1'b0;
      row_done       <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      mac_en     <= 1'b0;
      acc_clr    <= 1'b0;
      if_release <= 1'b0;
      row_done   <= 1'b0;
      cfg_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (illegal) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_stride <= stride;
              cfg_fs     <= filter_size;
              cfg_is     <= if_size;
              f          <= '0;
              w          <= '0;
              k          <= '0;
              busy       <= 1'b1;
              state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // Missing operands simply hold every counter until they arrive.
          if (can_issue) begin
            mac_en         <= 1'b1;
            acc_clr        <= (k == 3'd0);
            if_rd_addr     <= IF_ADDRESS_SIZE'(mod_add(32'(if_base), off, 32'(CELL_NUMS_IF)));
            filter_rd_addr <= FILTER_ADDRESS_SIZE'(mod_add(32'd0, fidx, 32'(CELL_NUMS_FILTER)));
            if (last_k) begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end else begin
              k <= k + 3'd1;
            end
          end
        end
        S_DRAIN: begin
          // The first DRAIN cycle is the one carrying the last tap's mac_en.
          if (drain_cnt == 2'(MAC_LATENCY - 1)) begin
            psum_valid  <= 1'b1;
            psum_filter <= 3'(f);
            psum_win    <= w;
            state       <= S_EMIT;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        S_EMIT: begin
          if (psum_ready) begin
            psum_valid <= 1'b0;
            k          <= '0;
            if (last_w) begin
              w <= '0;
              if (last_f) begin
                f          <= '0;
                if_release <= 1'b1;
                row_done   <= 1'b1;
                if_base    <= IF_ADDRESS_SIZE'(mod_add(32'(if_base), 32'(cfg_is), 32'(CELL_NUMS_IF)));
                state      <= S_RELEASE;
              end else begin
                f     <= f + NF_W'(1);
                state <= S_ISSUE;
              end
            end else begin
              w     <= w + 3'd1;
              state <= S_ISSUE;
            end
          end
        end
        S_RELEASE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
